// File: rtl/led_seq_ctrl.sv
// Four-LED pattern sequencer: prescaled step tick driving all-blink, chase, bounce or count.
// Optional macro LED_PWM_EN adds a brightness_in port and a 16-level PWM mask on the LEDs.
module led_seq_ctrl #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned CNT_W    = 24
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [1:0] mode_in,
  input  logic       mode_load_in,
  input  logic       run_in,
`ifdef LED_PWM_EN
  input  logic [3:0] brightness_in,
`endif
  output logic       led_1,
  output logic       led_2,
  output logic       led_3,
  output logic       led_4,
  output logic       tick_out,
  output logic       busy_out
);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  localparam logic [1:0] ModeBlink  = 2'd0;
  localparam logic [1:0] ModeChase  = 2'd1;
  localparam logic [1:0] ModeBounce = 2'd2;
  localparam logic [1:0] ModeCount  = 2'd3;

  localparam logic [CNT_W-1:0] PrescLast = CNT_W'(TICK_DIV - 1);

  state_e           state_q;
  logic [1:0]       mode_q;
  logic [3:0]       step_q;
  logic [CNT_W-1:0] presc_q;

  logic       tick;
  logic [3:0] step_next;
  logic [3:0] pattern;
  logic [3:0] led_vec;

  assign tick = (state_q == StRun) && (presc_q == PrescLast);

  always_comb begin
    step_next = 4'd0;
    unique case (mode_q)
      ModeBlink:  step_next = (step_q == 4'd0) ? 4'd1 : 4'd0;
      ModeChase:  step_next = (step_q >= 4'd3) ? 4'd0 : step_q + 4'd1;
      ModeBounce: step_next = (step_q >= 4'd5) ? 4'd0 : step_q + 4'd1;
      ModeCount:  step_next = step_q + 4'd1;
      default:    step_next = 4'd0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      mode_q  <= 2'd0;
      step_q  <= 4'd0;
      presc_q <= '0;
    end else if (mode_load_in) begin
      // A load wins over a coincident tick and over run_in.
      mode_q  <= mode_in;
      state_q <= StIdle;
      step_q  <= 4'd0;
      presc_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run_in) state_q <= StRun;
        end
        StRun: begin
          if (!run_in) state_q <= StPause;
          if (tick) begin
            presc_q <= '0;
            step_q  <= step_next;
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        StPause: begin
          if (run_in) state_q <= StRun;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    pattern = 4'b0000;
    unique case (mode_q)
      ModeBlink:  pattern = (step_q == 4'd1) ? 4'b1111 : 4'b0000;
      ModeChase:  pattern = 4'b0001 << step_q[1:0];
      ModeBounce: begin
        case (step_q)
          4'd0:    pattern = 4'b0001;
          4'd1:    pattern = 4'b0010;
          4'd2:    pattern = 4'b0100;
          4'd3:    pattern = 4'b1000;
          4'd4:    pattern = 4'b0100;
          4'd5:    pattern = 4'b0010;
          default: pattern = 4'b0000;
        endcase
      end
      ModeCount:  pattern = step_q;
      default:    pattern = 4'b0000;
    endcase
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;
  logic       pwm_on;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pwm_cnt <= 4'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 4'd1;
    end
  end

  assign pwm_on  = (pwm_cnt < brightness_in);
  assign led_vec = (state_q == StIdle) ? 4'b0000 : (pattern & {4{pwm_on}});
`else
  assign led_vec = (state_q == StIdle) ? 4'b0000 : pattern;
`endif

  assign led_1    = led_vec[0];
  assign led_2    = led_vec[1];
  assign led_3    = led_vec[2];
  assign led_4    = led_vec[3];
  assign tick_out = tick;
  assign busy_out = (state_q != StIdle);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Bench for led_seq_ctrl: per-cycle comparison against a table-driven model plus directed literals.
module tb_led_seq_ctrl;

  localparam int unsigned TickDiv = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic       run;
  logic [1:0] mode_in;
  logic [3:0] bright;
  logic       led_1, led_2, led_3, led_4, tick, busy;
  logic [3:0] leds;

  always #5 clk = ~clk;

  assign leds = {led_4, led_3, led_2, led_1};

  led_seq_ctrl #(
    .TICK_DIV(TickDiv),
    .CNT_W   (24)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .mode_in      (mode_in),
    .mode_load_in (load),
    .run_in       (run),
`ifdef LED_PWM_EN
    .brightness_in(bright),
`endif
    .led_1        (led_1),
    .led_2        (led_2),
    .led_3        (led_3),
    .led_4        (led_4),
    .tick_out     (tick),
    .busy_out     (busy)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Model: 0 idle, 1 run, 2 pause; m_cnt is cycles elapsed in the current step.
  int         m_st   = 0;
  int         m_mode = 0;
  int         m_step = 0;
  int         m_cnt  = 0;
  int         m_pwm  = 0;
  int         seq_len[4] = '{2, 4, 6, 16};
  logic [3:0] bnc[6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
  logic [3:0] pat[4][16];

  initial begin
    for (int s = 0; s < 16; s++) begin
      pat[0][s] = (s % 2 == 1) ? 4'hF : 4'h0;
      pat[1][s] = 4'(1 << (s % 4));
      pat[2][s] = bnc[s % 6];
      pat[3][s] = 4'(s);
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_st <= 0; m_mode <= 0; m_step <= 0; m_cnt <= 0;
    end else if (load) begin
      m_st <= 0; m_mode <= int'(mode_in); m_step <= 0; m_cnt <= 0;
    end else begin
      if (m_st == 1) begin
        if (m_cnt == TickDiv - 1) begin
          m_cnt  <= 0;
          m_step <= (m_step + 1) % seq_len[m_mode];
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
      if (m_st == 0 && run) m_st <= 1;
      else if (m_st == 1 && !run) m_st <= 2;
      else if (m_st == 2 && run) m_st <= 1;
    end
    m_pwm <= rst ? 0 : (m_pwm + 1) % 16;
  end

  function automatic logic [3:0] exp_leds();
    logic [3:0] p;
    p = (m_st == 0) ? 4'h0 : pat[m_mode][m_step];
`ifdef LED_PWM_EN
    if (m_pwm >= int'(bright)) p = 4'h0;
`endif
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // LED literals assume full brightness, so they only apply without the PWM mask.
  task automatic chk_led(input string name, input logic [3:0] exp);
`ifndef LED_PWM_EN
    check(name, 32'(leds), 32'(exp));
`endif
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("model_leds", 32'(leds), 32'(exp_leds()));
      check("model_tick", 32'(tick), 32'((m_st == 1) && (m_cnt == TickDiv - 1)));
      check("model_busy", 32'(busy), 32'(m_st != 0));
    end
  end

  task automatic step_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 2 * TickDiv && !found; k++) begin
      if (tick) found = 1'b1;
      else step_cyc();
    end
    check(name, 32'(found), 32'd1);
  endtask

  logic [3:0] bounce_exp[7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
  logic [3:0] chase_exp[5]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  int         high_cnt;

  initial begin
    rst = 1'b1; run = 1'b1; mode_in = 2'd3; load = 1'b0; bright = 4'hF;

    // Reset held three cycles with run and mode asserted.
    for (int i = 0; i < 3; i++) begin
      step_cyc();
      check_en = 1'b1;
      chk_led("rst_leds", 4'h0);
      check("rst_tick", 32'(tick), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b0; run = 1'b0;
    step_cyc();
    check("post_rst_idle", 32'(busy), 32'd0);

    // CHASE
    load = 1'b1; mode_in = 2'd1;
    step_cyc();
    load = 1'b0; run = 1'b1;
    chk_led("chase_load_leds", 4'h0);
    for (int i = 0; i <= 16; i++) begin
      step_cyc();
      chk_led("chase_leds", chase_exp[i / 4]);
      check("chase_tick", 32'(tick), 32'(i % 4 == 3));
    end

    // BOUNCE, load with run held high: one idle cycle then RUN
    load = 1'b1; mode_in = 2'd2;
    step_cyc();
    load = 1'b0;
    check("bounce_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i <= 24; i++) begin
      step_cyc();
      if (i % 4 == 0) chk_led("bounce_leds", bounce_exp[i / 4]);
    end

    // COUNT wrap
    load = 1'b1; mode_in = 2'd3;
    step_cyc();
    load = 1'b0;
    for (int i = 0; i <= 64; i++) begin
      step_cyc();
      if (i == 60) chk_led("count_15", 4'hF);
      if (i == 63) check("count_tick63", 32'(tick), 32'd1);
      if (i == 64) chk_led("count_wrap", 4'h0);
    end

    // Pause with two cycles of the step already counted
    for (int i = 0; i < 5; i++) step_cyc();
    chk_led("pre_pause", 4'h1);
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_cyc();
      chk_led("pause_hold", 4'h1);
      check("pause_tick", 32'(tick), 32'd0);
      check("pause_busy", 32'(busy), 32'd1);
    end
    run = 1'b1;
    step_cyc();
    check("resume_tick0", 32'(tick), 32'd0);
    step_cyc();
    check("resume_tick1", 32'(tick), 32'd1);
    step_cyc();
    chk_led("resume_next", 4'h2);

    // Load coinciding with a tick
    wait_tick("wait_tick");
    load = 1'b1; mode_in = 2'd0;
    step_cyc();
    load = 1'b0;
    chk_led("load_tick_leds", 4'h0);
    check("load_tick_busy", 32'(busy), 32'd0);
    step_cyc();
    check("load_run_busy", 32'(busy), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      step_cyc();
      if (j == 3) check("blink_tick", 32'(tick), 32'd1);
      if (j == 3) chk_led("blink_step0", 4'h0);
      if (j == 4) chk_led("blink_step1", 4'hF);
    end

`ifdef LED_PWM_EN
    // Paused on step 1 so the pattern is all-on; only the PWM mask varies.
    run = 1'b0; bright = 4'd4;
    step_cyc();
    high_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step_cyc();
      if (led_1) high_cnt++;
    end
    check("pwm_duty4", 32'(high_cnt), 32'd4);
    bright = 4'd0;
    high_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step_cyc();
      if (led_1 | led_2 | led_3 | led_4) high_cnt++;
    end
    check("pwm_duty0", 32'(high_cnt), 32'd0);
    run = 1'b1;
`endif

    // Reset while running
    rst = 1'b1;
    step_cyc();
    chk_led("rst_run_leds", 4'h0);
    check("rst_run_busy", 32'(busy), 32'd0);
    rst = 1'b0; run = 1'b0;
    step_cyc();
    step_cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/led_seq_ctrl.md
# led_seq_ctrl

Pattern sequencer for the board's four user LEDs. It produces a programmable blink tick from the board clock and steps a small state machine through one of four selectable patterns: all-blink, chase, bounce or binary count. It replaces free-running per-LED toggle logic at the top level and sits directly between the board clock/user controls and the LED pins.

## Interface
- TICK_DIV, 10000000: board-clock cycles per pattern step; legal range 2 to 2^CNT_W-1.
- CNT_W, 24: prescaler counter width.
- clk_in  input  1  board clock; all logic on its rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- mode_in  input  2  pattern select: 0 ALL_BLINK, 1 CHASE, 2 BOUNCE, 3 COUNT.
- mode_load_in  input  1  one-cycle strobe; captures mode_in.
- run_in  input  1  level; 1 = sequence advances, 0 = hold.
- brightness_in  input  4  PWM duty; present only with LED_PWM_EN.
- led_1..led_4  output  1 each  LED drives; led_1 is bit 0 of the pattern.
- tick_out  output  1  one-cycle pulse per pattern step.
- busy_out  output  1  high when the state is not IDLE.

## Operation
- Registers:
  - state: IDLE, RUN or PAUSE.
  - mode_r: 2 bits.
  - step: 4 bits.
  - presc: CNT_W bits.
- Reset (rst_in=1 at an edge):
  - state=IDLE, mode_r=0, step=0, presc=0.
  - All LEDs 0, tick_out=0, busy_out=0.
  - Reset overrides every other input in that cycle.
- mode_load_in=1, highest priority after reset:
  - mode_r←mode_in, state←IDLE, step←0, presc←0.
  - Applies from any state.
  - run_in is ignored in that cycle.
- State transitions, evaluated only when no reset and no load:
  - IDLE→RUN when run_in=1.
  - RUN→PAUSE when run_in=0.
  - PAUSE→RUN when run_in=1.
  - Otherwise the state holds.
- Prescaler behaviour by state:
  - RUN: presc counts 0..TICK_DIV-1. When presc=TICK_DIV-1, presc wraps to 0, tick_out=1 for that cycle, and step advances.
  - IDLE and PAUSE: presc is frozen.
  - PAUSE→RUN resumes from the held presc value; no count is lost or restarted.
- Step advance per mode:
  - ALL_BLINK: step toggles between 0 and 1.
  - CHASE: 0..3, wrapping to 0.
  - BOUNCE: 0..5, wrapping to 0.
  - COUNT: 0..15, wrapping to 0.
- Pattern decode (LED vector {led_4,led_3,led_2,led_1}), decoded from the registered step and mode_r:
  - ALL_BLINK: 0000 when step=0, 1111 when step=1.
  - CHASE: one-hot, 1<<step.
  - BOUNCE: 0001, 0010, 0100, 1000, 0100, 0010 for step 0..5.
  - COUNT: step as a binary value.
- LED output by state:
  - IDLE: 0000.
  - RUN and PAUSE: the decoded pattern. PAUSE holds the last pattern.
- tick_out is combinational from the registered state and presc only: tick_out = (state==RUN) && (presc==TICK_DIV-1).

## Timing
- Entry into RUN:
  - Edge N samples run_in=1 while in IDLE.
  - From cycle N+1, state=RUN and the LEDs show pattern(step=0).
- First step:
  - The first tick_out occurs in the TICK_DIV-th cycle of RUN.
  - The new pattern appears on the following cycle.
  - Each step lasts exactly TICK_DIV cycles while running.
- Pause latency: run_in falling is sampled at the next edge. The LEDs and presc freeze from the cycle after that edge.
- mode_load_in latency: the LEDs read 0000 in the cycle after the strobe.
- Simultaneous events:
  - A load on a tick cycle wins. step is set to 0, not advanced.
  - A load while run_in=1 gives one IDLE cycle, then RUN.

## Configuration
- Macro LED_PWM_EN.
- When defined:
  - A free-running 4-bit pwm_cnt is added. It resets to 0 and increments every cycle in all states.
  - Each LED output = pattern bit AND (pwm_cnt < brightness_in). Duty is brightness_in/16; 0 means always off.
- When undefined:
  - The brightness_in port and pwm_cnt do not exist.
  - LEDs equal the pattern bits directly.

## Test plan
All tests use TICK_DIV=4.
- Reset: hold rst_in=1 for 3 cycles with run_in=1 and mode_in=3 → LEDs 0000, tick_out=0, busy_out=0 throughout. The state stays IDLE until the first edge after rst_in falls.
- CHASE run: load mode 1, then run_in=1 → LEDs 0001 for 4 cycles, then 0010, 0100, 1000, 0001. tick_out pulses every 4th cycle.
- BOUNCE and COUNT wrap:
  - Mode 2 gives 0001,0010,0100,1000,0100,0010,0001.
  - Mode 3 reaches 1111, then 0000 after the next tick.
- Pause mid-step: in RUN with presc=2, drop run_in for 10 cycles → LEDs hold and there is no tick. After resume, tick_out arrives exactly 2 cycles after re-entering RUN.
- Load during RUN coinciding with a tick: pulse mode_load_in in the tick_out=1 cycle with mode_in=0 → next cycle LEDs 0000 and busy_out=0. With run_in held high, RUN follows one cycle later with step=0.
- PWM (LED_PWM_EN defined): mode 0, brightness_in=4, step=1 → each LED is high for exactly 4 of every 16 cycles. brightness_in=0 → LEDs constant 0.
